// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that shares one UART byte transmitter among N_REQ requesters.
// The grant is held for a whole message, then a fixed idle gap follows.
module uart_tx_arb #(
   parameter int N_REQ      = 4,
   parameter int GAP_CYCLES = 5208,
   parameter int BUSY_TO    = 16
) (
   input  logic                 clk_50m_i,
   input  logic                 rst_n_i,
   input  logic [N_REQ-1:0]     req_i,
   input  logic [8*N_REQ-1:0]   data_i,
   input  logic [N_REQ-1:0]     last_i,
   output logic [N_REQ-1:0]     ack_o,
   output logic [N_REQ-1:0]     grant_o,
   output logic                 tx_start_o,
   output logic [7:0]           tx_data_o,
   input  logic                 tx_busy_i,
   output logic                 abort_o,
   output logic                 timeout_o
);

   localparam int IW = $clog2(N_REQ);
   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam int TW = $clog2(BUSY_TO + 1);
   localparam logic [GW-1:0]    GAP_LAST = GW'(GAP_CYCLES - 1);
   localparam logic [TW-1:0]    TO_LAST  = TW'(BUSY_TO - 1);
   localparam logic [N_REQ-1:0] ONE      = N_REQ'(1);

   typedef enum logic [2:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE, GAP} state_t;

   state_t        state;
   logic [IW-1:0] rr_ptr;
   logic [IW-1:0] owner;
   logic [IW-1:0] pick;
   logic          pick_valid;
   logic [GW-1:0] gap_cnt;
   logic [TW-1:0] to_cnt;
   logic          last_q;
   logic          cur_req;
   logic          cur_last;
   logic [7:0]    cur_data;
   logic [IW-1:0] next_ptr;

   // First pending requester at or after rr_ptr, with wrap; scanning downward
   // lets the smallest offset from the pointer win.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      pick       = '0;
      pick_valid = 1'b0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req_i[(int'(rr_ptr) + i) % N_REQ]) begin
            pick       = IW'((int'(rr_ptr) + i) % N_REQ);
            pick_valid = 1'b1;
         end
      end
   end

   always_comb begin
      cur_req  = 1'b0;
      cur_last = 1'b0;
      cur_data = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (owner == IW'(k)) begin
            cur_req  = req_i[k];
            cur_last = last_i[k];
            cur_data = data_i[8*k +: 8];
         end
      end
   end

   assign next_ptr = (owner == IW'(N_REQ - 1)) ? '0 : owner + IW'(1);

   always_ff @(posedge clk_50m_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         owner      <= '0;
         gap_cnt    <= '0;
         to_cnt     <= '0;
         last_q     <= 1'b0;
         grant_o    <= '0;
         ack_o      <= '0;
         tx_start_o <= 1'b0;
         tx_data_o  <= '0;
         abort_o    <= 1'b0;
         timeout_o  <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments; pulses default
         // low here and are raised only by the branch that owns them.
         ack_o      <= '0;
         tx_start_o <= 1'b0;
         abort_o    <= 1'b0;
         timeout_o  <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  grant_o <= ONE << pick;
                  owner   <= pick;
                  state   <= LOAD;
               end
            end
            LOAD: begin
               if (cur_req) begin
                  tx_data_o  <= cur_data;
                  last_q     <= cur_last;
                  tx_start_o <= 1'b1;
                  ack_o      <= ONE << owner;
                  to_cnt     <= '0;
                  state      <= WAIT_BUSY;
               end else begin
                  abort_o <= 1'b1;
                  gap_cnt <= '0;
                  state   <= GAP;
               end
            end
            WAIT_BUSY: begin
               if (tx_busy_i) begin
                  state <= WAIT_DONE;
               end else if (to_cnt == TO_LAST) begin
                  timeout_o <= 1'b1;
                  gap_cnt   <= '0;
                  state     <= GAP;
               end else begin
                  to_cnt <= to_cnt + TW'(1);
               end
            end
            WAIT_DONE: begin
               if (!tx_busy_i) begin
                  if (last_q) begin
                     gap_cnt <= '0;
                     state   <= GAP;
                  end else begin
                     state <= LOAD;
                  end
               end
            end
            GAP: begin
               // Owner keeps the grant through the gap, then drops to lowest priority.
               if (gap_cnt == GAP_LAST) begin
                  grant_o <= '0;
                  rr_ptr  <= next_ptr;
                  state   <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt + GW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
